// File: rtl/qram_access_sequencer.sv
// Sequencer for a bit-cell array: turns single-bit read/write commands into
// timed per-cell strobes and periodically refreshes each cell by read-writeback.
module qram_access_sequencer #(
    parameter int unsigned ADDR_W           = 4,
    parameter int unsigned STROBE_CYCLES    = 2,
    parameter int unsigned REFRESH_INTERVAL = 64
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic                   CmdValid,
    output logic                   CmdReady,
    input  logic                   CmdWrite,
    input  logic [ADDR_W-1:0]      CmdAddress,
    input  logic                   CmdData,
    output logic                   RspValid,
    input  logic                   RspReady,
    output logic                   RspData,
    output logic [2**ADDR_W-1:0]   ReadEdge,
    output logic [2**ADDR_W-1:0]   WriteEdge,
    output logic                   CellDataIn,
    input  logic                   CellDataOut,
    output logic                   Busy
);

    localparam int unsigned N      = 2**ADDR_W;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned CNT_W  = $clog2(REFRESH_INTERVAL);

    typedef enum logic [3:0] {
        IDLE, SETUP, STROBE, HOLD, RESPOND,
        REF_READ, REF_SETUP, REF_WRITE, REF_HOLD
    } stateT;

    stateT              state, nextState;
    logic [STEP_W-1:0]  stepCnt, stepNext;
    logic [CNT_W-1:0]   refreshCnt;
    logic               refreshPending, pendingNext;
    logic [ADDR_W-1:0]  refreshAddr, refreshAddrNext;
    logic [ADDR_W-1:0]  addrQ, addrNext;
    logic               writeQ, writeNext, dataQ, dataNext;
    logic               refBit, refBitNext, rspDataNext;
    logic [N-1:0]       readEdgeNext, writeEdgeNext, cmdSel, refSel;
    logic               cellDataInNext;
    logic               accept, stepLast, refreshWrap;

    assign accept      = CmdValid & CmdReady;
    assign stepLast    = (stepCnt == STEP_W'(STROBE_CYCLES - 1));
    assign refreshWrap = (refreshCnt == CNT_W'(REFRESH_INTERVAL - 1));

    // Next-state, latched command fields, and the outputs of the state being entered
    always_comb begin
        nextState       = state;
        stepNext        = '0;
        pendingNext     = refreshPending | refreshWrap;
        refreshAddrNext = refreshAddr;
        addrNext        = addrQ;
        writeNext       = writeQ;
        dataNext        = dataQ;
        refBitNext      = refBit;
        rspDataNext     = RspData;
        readEdgeNext    = '0;
        writeEdgeNext   = '0;
        cellDataInNext  = 1'b0;

        case (state)
            IDLE: begin
                if (refreshPending) begin
                    nextState   = REF_READ;
                    pendingNext = 1'b0;
                end else if (accept) begin
                    nextState   = SETUP;
                    addrNext    = CmdAddress;
                    writeNext   = CmdWrite;
                    dataNext    = CmdData;
                    rspDataNext = 1'b0;
                end
            end
            SETUP:   nextState = STROBE;
            STROBE: begin
                if (stepLast) begin
                    nextState = HOLD;
                    if (!writeQ) rspDataNext = CellDataOut;
                end else begin
                    stepNext = stepCnt + STEP_W'(1);
                end
            end
            HOLD:    nextState = RESPOND;
            RESPOND: if (RspReady) nextState = IDLE;
            REF_READ: begin
                if (stepLast) begin
                    nextState  = REF_SETUP;
                    refBitNext = CellDataOut;
                end else begin
                    stepNext = stepCnt + STEP_W'(1);
                end
            end
            REF_SETUP: nextState = REF_WRITE;
            REF_WRITE: begin
                if (stepLast) nextState = REF_HOLD;
                else          stepNext  = stepCnt + STEP_W'(1);
            end
            REF_HOLD: begin
                nextState       = IDLE;
                refreshAddrNext = refreshAddr + ADDR_W'(1);
            end
            default: nextState = IDLE;
        endcase

        cmdSel = N'(1) << addrNext;
        refSel = N'(1) << refreshAddrNext;

        case (nextState)
            SETUP, HOLD: cellDataInNext = writeNext & dataNext;
            STROBE: begin
                cellDataInNext = writeNext & dataNext;
                if (writeNext) writeEdgeNext = cmdSel;
                else           readEdgeNext  = cmdSel;
            end
            REF_READ:            readEdgeNext   = refSel;
            REF_SETUP, REF_HOLD: cellDataInNext = refBitNext;
            REF_WRITE: begin
                writeEdgeNext  = refSel;
                cellDataInNext = refBitNext;
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs; reset drops strobes immediately
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state          <= IDLE;
            stepCnt        <= '0;
            refreshCnt     <= '0;
            refreshPending <= 1'b0;
            refreshAddr    <= '0;
            addrQ          <= '0;
            writeQ         <= 1'b0;
            dataQ          <= 1'b0;
            refBit         <= 1'b0;
            CmdReady       <= 1'b0;
            RspValid       <= 1'b0;
            RspData        <= 1'b0;
            ReadEdge       <= '0;
            WriteEdge      <= '0;
            CellDataIn     <= 1'b0;
            Busy           <= 1'b0;
        end else begin
            state          <= nextState;
            stepCnt        <= stepNext;
            refreshCnt     <= refreshWrap ? '0 : refreshCnt + CNT_W'(1);
            refreshPending <= pendingNext;
            refreshAddr    <= refreshAddrNext;
            addrQ          <= addrNext;
            writeQ         <= writeNext;
            dataQ          <= dataNext;
            refBit         <= refBitNext;
            CmdReady       <= (nextState == IDLE) && !pendingNext;
            RspValid       <= (nextState == RESPOND);
            RspData        <= rspDataNext;
            ReadEdge       <= readEdgeNext;
            WriteEdge      <= writeEdgeNext;
            CellDataIn     <= cellDataInNext;
            Busy           <= (nextState != IDLE);
        end
    end

endmodule

// File: tb/tb_qram_access_sequencer.sv
// Scoreboard bench for qram_access_sequencer with a behavioural bit-cell array.
module tb_qram_access_sequencer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned N      = 16;
    localparam int unsigned RI     = 64;
    localparam logic [15:0] INIT   = 16'hA5C3;

    logic              Clock = 1'b0;
    logic              nReset = 1'b1;
    logic              CmdValid = 1'b0, CmdWrite = 1'b0, CmdData = 1'b0;
    logic [ADDR_W-1:0] CmdAddress = '0;
    logic              RspReady = 1'b1;
    logic              CmdReady, RspValid, RspData, CellDataIn, CellDataOut, Busy;
    logic [N-1:0]      ReadEdge, WriteEdge;

    logic [N-1:0]      mem = INIT;
    logic [N-1:0]      model = INIT;
    logic              armed = 1'b0;
    logic              expQ[$];
    int                checks = 0;
    int                failures = 0;

    qram_access_sequencer #(.ADDR_W(ADDR_W), .STROBE_CYCLES(2), .REFRESH_INTERVAL(RI)) dut (
        .Clock(Clock), .nReset(nReset),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrite(CmdWrite),
        .CmdAddress(CmdAddress), .CmdData(CmdData),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
        .ReadEdge(ReadEdge), .WriteEdge(WriteEdge),
        .CellDataIn(CellDataIn), .CellDataOut(CellDataOut), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // Cell array: shared data lines, write on the clock edge while strobed
    assign CellDataOut = |(ReadEdge & mem);
    always @(posedge Clock)
        if (armed) mem <= (mem & ~WriteEdge) | (WriteEdge & {N{CellDataIn}});

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int idxOf(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic monitorLoop();
        logic e;
        forever begin
            @(negedge Clock);
            if (nReset) begin
                if (RspValid && RspReady) begin
                    if (expQ.size() == 0) check("rsp_unexpected", 64'(RspValid), 64'(0));
                    else begin
                        e = expQ.pop_front();
                        check("rsp_data", 64'(RspData), 64'(e));
                    end
                end
                check("strobe_excl",
                      64'(!$onehot0(ReadEdge) || !$onehot0(WriteEdge) ||
                          ((|ReadEdge) && (|WriteEdge)) || ((|(ReadEdge | WriteEdge)) && !Busy)),
                      64'(0));
            end
        end
    endtask

    task automatic doReset();
        @(negedge Clock);
        nReset = 1'b0; CmdValid = 1'b0; RspReady = 1'b1;
        #1;
        check("reset_outputs", 64'({ReadEdge, WriteEdge, CellDataIn, RspValid, RspData, CmdReady, Busy}), 64'(0));
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin @(negedge Clock); n++; end
        check("drain_queue", 64'(expQ.size()), 64'(0));
    endtask

    // Issue one command; optionally check cycle-exact phases and a stalled response
    task automatic doCmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic data,
                         input bit timed, input bit hold);
        int waitCnt;
        logic [N-1:0] oh;
        logic dIn, expRsp;
        logic [2*N+1:0] exp;
        oh = 16'(1) << addr;
        dIn = wr & data;
        expRsp = wr ? 1'b0 : model[addr];
        expQ.push_back(expRsp);
        if (wr) model[addr] = data;
        @(posedge Clock); #1;
        RspReady = !hold;
        CmdValid = 1'b1; CmdWrite = wr; CmdAddress = addr; CmdData = data;
        waitCnt = 0;
        @(negedge Clock);
        while (!CmdReady && waitCnt < 300) begin @(negedge Clock); waitCnt++; end
        if (!CmdReady) begin
            check("accept_timeout", 64'(CmdReady), 64'(1));
            CmdValid = 1'b0;
            void'(expQ.pop_back());
            return;
        end
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        if (timed) begin
            for (int k = 1; k <= 5; k++) begin
                @(negedge Clock);
                exp = {(k == 2 || k == 3) && !wr ? oh : 16'(0),
                       (k == 2 || k == 3) &&  wr ? oh : 16'(0),
                       k <= 4 ? dIn : 1'b0,
                       k == 5 ? 1'b1 : 1'b0};
                check($sformatf("cmd_phase%0d_wr%0b", k, wr),
                      64'({ReadEdge, WriteEdge, CellDataIn, RspValid}), 64'(exp));
            end
            if (hold) begin
                for (int h = 0; h < 3; h++) begin
                    if (h != 0) @(negedge Clock);
                    check("rsp_hold", 64'({RspValid, RspData}), 64'({1'b1, expRsp}));
                end
                @(posedge Clock); #1;
                RspReady = 1'b1;
            end
        end
    endtask

    initial begin
        int waitCnt, refs;
        logic [N-1:0] prevRead;
        logic m0;
        logic [2*N+2:0] exp;

        doReset();
        armed = 1'b1;
        fork monitorLoop(); join_none
        @(negedge Clock);
        check("post_reset", 64'({CmdReady, Busy, RspValid}), 64'(3'b100));

        // Basic writes and reads with exact timing
        doCmd(1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
        doCmd(1'b0, 4'd5, 1'b0, 1'b1, 1'b1);
        doCmd(1'b1, 4'd15, 1'b0, 1'b1, 1'b0);
        doCmd(1'b0, 4'd15, 1'b0, 1'b1, 1'b0);
        doCmd(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        doCmd(1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        doCmd(1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
        drain();

        // Refresh collides with an offered command right after reset
        doReset();
        m0 = model[0];
        repeat (RI) @(posedge Clock);
        #1;
        expQ.push_back(m0);
        CmdValid = 1'b1; CmdWrite = 1'b0; CmdAddress = 4'd0; CmdData = 1'b0;
        for (int p = 0; p <= 7; p++) begin
            @(negedge Clock);
            case (p)
                0:       exp = {1'b0, 1'b0, 16'h0, 16'h0, 1'b0};
                1, 2:    exp = {1'b0, 1'b1, 16'h1, 16'h0, 1'b0};
                3, 6:    exp = {1'b0, 1'b1, 16'h0, 16'h0, m0};
                4, 5:    exp = {1'b0, 1'b1, 16'h0, 16'h1, m0};
                default: exp = {1'b1, 1'b0, 16'h0, 16'h0, 1'b0};
            endcase
            check($sformatf("refresh_collide_p%0d", p),
                  64'({CmdReady, Busy, ReadEdge, WriteEdge, CellDataIn}), 64'(exp));
        end
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        @(negedge Clock);
        check("collide_cmd_accepted", 64'(Busy), 64'(1));
        drain();

        // Reset asserted in the middle of a write strobe
        @(posedge Clock); #1;
        CmdValid = 1'b1; CmdWrite = 1'b1; CmdAddress = 4'd9; CmdData = model[9];
        waitCnt = 0;
        @(negedge Clock);
        while (!CmdReady && waitCnt < 300) begin @(negedge Clock); waitCnt++; end
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        waitCnt = 0;
        @(negedge Clock);
        while (WriteEdge == '0 && waitCnt < 10) begin @(negedge Clock); waitCnt++; end
        check("midop_strobe_seen", 64'(WriteEdge), 64'(16'h0200));
        nReset = 1'b0;
        #1;
        check("reset_midop", 64'({ReadEdge, WriteEdge, RspValid, CmdReady, Busy}), 64'(0));
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        check("post_midop_reset", 64'({CmdReady, Busy, RspValid}), 64'(3'b100));

        // 2*N idle refreshes walk the address twice and preserve contents
        refs = 0;
        waitCnt = 0;
        prevRead = '0;
        while (refs < 2 * int'(N) && waitCnt < 2 * int'(N) * int'(RI) + 2 * int'(RI)) begin
            @(negedge Clock);
            waitCnt++;
            if (ReadEdge != '0 && prevRead == '0) begin
                check("refresh_addr", 64'(idxOf(ReadEdge)), 64'(refs % int'(N)));
                refs++;
            end
            prevRead = ReadEdge;
        end
        check("refresh_count", 64'(refs), 64'(2 * N));
        for (int i = 0; i < int'(N); i++)
            doCmd(1'b0, ADDR_W'(i), 1'b0, 1'b0, 1'b0);
        drain();
        repeat (5) @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qram_access_sequencer.md
QRAM_ACCESS_SEQUENCER -- requirements
Module: qram_access_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4, cell address width; the array has N = 2**ADDR_W cells.
REQ-002 Parameter STROBE_CYCLES, default 2, width of each read/write strobe in clocks (legal range 1..15).
REQ-003 Parameter REFRESH_INTERVAL, default 64, clocks between refresh requests (legal range >= 16).
REQ-004 Port Clock, input, 1, single clock; all state changes on the rising edge.
REQ-005 Port nReset, input, 1, reset; asynchronous assertion, active-low.
REQ-006 Port CmdValid, input, 1, command offered.
REQ-007 Port CmdReady, output, 1, sequencer accepts the command this cycle.
REQ-008 Port CmdWrite, input, 1, 1 = write, 0 = read.
REQ-009 Port CmdAddress, input, ADDR_W, target cell.
REQ-010 Port CmdData, input, 1, write data bit.
REQ-011 Port RspValid, output, 1, response available.
REQ-012 Port RspReady, input, 1, consumer takes the response.
REQ-013 Port RspData, output, 1, read result; 0 for write responses.
REQ-014 Port ReadEdge, output, N, per-cell read strobe; at most one bit high.
REQ-015 Port WriteEdge, output, N, per-cell write strobe; at most one bit high.
REQ-016 Port CellDataIn, output, 1, shared write-data line to all cells.
REQ-017 Port CellDataOut, input, 1, shared read-data line from all cells.
REQ-018 Port Busy, output, 1, high in every state except IDLE.

Function
REQ-019 The block SHALL implement these states: IDLE, SETUP, STROBE, HOLD, RESPOND, REF_READ, REF_SETUP, REF_WRITE, REF_HOLD.
REQ-020 CmdReady SHALL be 1 only in IDLE with no refresh pending; acceptance = CmdValid & CmdReady.
REQ-021 On acceptance, the block SHALL latch CmdAddress, CmdWrite and CmdData, then go to SETUP.
REQ-022 SETUP SHALL last 1 cycle with no strobe; CellDataIn = the latched data for writes, 0 for reads.
REQ-023 STROBE SHALL last exactly STROBE_CYCLES cycles with WriteEdge[addr] (write) or ReadEdge[addr] (read) high; CellDataIn SHALL be held.
REQ-024 A read SHALL capture CellDataOut into RspData on the last STROBE cycle.
REQ-025 HOLD SHALL last 1 cycle with all strobes 0 and CellDataIn still held; it then goes to RESPOND.
REQ-026 RESPOND SHALL assert RspValid with RspData stable until RspReady=1, then return to IDLE on the next cycle.
REQ-027 Latency: with acceptance at cycle T, RspValid SHALL rise at T+3+STROBE_CYCLES (T+5 at default).
REQ-028 A refresh counter SHALL count every cycle from 0 to REFRESH_INTERVAL-1, wrap to 0, and set RefreshPending on the wrap.
REQ-029 A wrap while RefreshPending is already set SHALL NOT queue a second refresh.
REQ-030 In IDLE, a pending refresh SHALL take priority over CmdValid; CmdReady SHALL be 0 in that cycle.
REQ-031 Refresh sequence: REF_READ strobes ReadEdge[RefreshAddr] for STROBE_CYCLES and captures CellDataOut on the last cycle.
REQ-032 The refresh SHALL then run REF_SETUP (1 cycle) and REF_WRITE (STROBE_CYCLES) to write the captured bit back, followed by REF_HOLD (1 cycle), then IDLE.
REQ-033 A refresh SHALL produce no response, SHALL clear RefreshPending on entry to REF_READ, and SHALL increment RefreshAddr modulo N on exit from REF_HOLD.
REQ-034 ReadEdge and WriteEdge SHALL never be nonzero in the same cycle, and never nonzero outside the STROBE, REF_READ and REF_WRITE states.
REQ-035 A refresh wrap occurring during a command SHALL stay pending and be served at the next IDLE.

Reset
REQ-036 While nReset=0, the block SHALL drive state IDLE, ReadEdge=0, WriteEdge=0, CellDataIn=0, RspValid=0, RspData=0 and CmdReady=0; counter, RefreshAddr and RefreshPending SHALL be 0.
REQ-037 Reset asserted mid-strobe SHALL drop all strobes asynchronously; the interrupted command is discarded with no response.
REQ-038 After nReset deasserts, the first refresh SHALL occur REFRESH_INTERVAL cycles later.

Verification
REQ-039 Write: write addr 5, data 1 at T -> WriteEdge[5] high at T+2 and T+3, CellDataIn=1 from T+1 to T+4, RspValid at T+5 with RspData=0.
REQ-040 Read: read addr 5 after the write -> ReadEdge[5] high for 2 cycles, RspData=1 at T+5; with RspReady held 0 for 3 cycles, RspValid and RspData stay stable.
REQ-041 Refresh collision: CmdValid high in the cycle RefreshPending is set -> CmdReady=0; the full refresh of addr 0 runs and completes; the command is then accepted.
REQ-042 Refresh wrap: 2*N refreshes -> RefreshAddr sequence 0..N-1, 0..N-1; cell contents are unchanged, checked by reads.
REQ-043 Reset mid-op: nReset low during STROBE -> strobes are 0 in the same cycle; after release, state is IDLE with CmdReady=1 and no RspValid.
REQ-044 Assertion throughout all tests: the one-hot and mutual-exclusion rule of REQ-034 is never violated.
